// File: rtl/chip8_timer_ctrl_if.sv
// chip8_timer_ctrl_if
// Request/response handshake between the CPU execute stage and the
// Chip-8 timer controller.
//   req_valid  CPU request present
//   req_op     00 read DT, 01 write DT, 10 write ST, 11 wait for DT == 0
//   req_data   write value for ops 01 and 10
//   req_ready  controller can accept a request
//   rsp_valid  one-cycle completion pulse
//   rsp_data   response value
interface chip8_timer_ctrl_if;
    logic       req_valid;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/chip8_timer_ctrl.sv
// chip8_timer_ctrl
// Owns the Chip-8 delay timer (DT) and sound timer (ST), the shared 60 Hz
// tick generator and the buzzer tone generator. CPU accesses arrive through
// a single request/response handshake and are sequenced IDLE -> EXEC -> RESP.
// Ports:
//   SYS_CLK    system clock, rising edge
//   SYS_RST_N  asynchronous active-low reset
//   bus        request/response handshake (slave side)
//   dt_value   current DT register
//   st_active  ST != 0
//   tone       buzzer square wave, low whenever ST == 0
//   tick       one-cycle 60 Hz tick pulse
module chip8_timer_ctrl #(
    parameter int TICK_DIV = 1666667,
    parameter int TONE_DIV = 113636
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RST_N,
    chip8_timer_ctrl_if.slave   bus,
    output logic [7:0]          dt_value,
    output logic                st_active,
    output logic                tone,
    output logic                tick
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

    localparam logic [1:0] OP_READ_DT  = 2'b00;
    localparam logic [1:0] OP_WRITE_DT = 2'b01;
    localparam logic [1:0] OP_WRITE_ST = 2'b10;
    localparam logic [1:0] OP_WAIT_DT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [7:0]        data_q;
    logic [7:0]        dt;
    logic [7:0]        st;
    logic [TICK_W-1:0] tick_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic              tone_q;
    logic              wr_dt;
    logic              wr_st;

    assign dt_value  = dt;
    assign st_active = (st != 8'd0);
    assign tick      = (tick_cnt == TICK_LAST);
    // The toggle flop is cleared one edge after ST reaches zero; masking keeps
    // the pin silent on that very cycle.
    assign tone      = tone_q & st_active;

    assign wr_dt = (state == EXEC) && (op_q == OP_WRITE_DT);
    assign wr_st = (state == EXEC) && (op_q == OP_WRITE_ST);

    // Free-running tick divider; requests never disturb its phase.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Timers: a write wins over the tick decrement of the same timer only;
    // zero saturates.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            dt <= 8'd0;
            st <= 8'd0;
        end else begin
            if (wr_dt) begin
                dt <= data_q;
            end else if (tick && (dt != 8'd0)) begin
                dt <= dt - 8'd1;
            end
            if (wr_st) begin
                st <= data_q;
            end else if (tick && (st != 8'd0)) begin
                st <= st - 8'd1;
            end
        end
    end

    // Tone divider runs only while ST is nonzero; starting from a held zero
    // puts the first toggle TONE_DIV cycles after ST leaves zero.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (st == 8'd0) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    // Captured request fields; only consulted in EXEC, so no reset needed.
    always_ff @(posedge SYS_CLK) begin
        if ((state == IDLE) && bus.req_valid) begin
            op_q   <= bus.req_op;
            data_q <= bus.req_data;
        end
    end

    // Request sequencer with registered handshake outputs.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    bus.rsp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    // DT is sampled before this edge's decrement, so a read
                    // on a tick edge sees the pre-decrement value.
                    if ((op_q != OP_WAIT_DT) || (dt == 8'd0)) begin
                        case (op_q)
                            OP_READ_DT: bus.rsp_data <= dt;
                            OP_WAIT_DT: bus.rsp_data <= 8'd0;
                            default:    bus.rsp_data <= data_q;
                        endcase
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
module tb_chip8_timer_ctrl;

    localparam int TICK_DIV = 10;
    localparam int TONE_DIV = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dt_value;
    logic       st_active;
    logic       tone;
    logic       tick;

    int total = 0;
    int bad   = 0;
    bit cmp_en   = 0;
    bit rsp_seen = 0;

    chip8_timer_ctrl_if bus();

    chip8_timer_ctrl #(
        .TICK_DIV(TICK_DIV),
        .TONE_DIV(TONE_DIV)
    ) dut (
        .SYS_CLK  (clk),
        .SYS_RST_N(rst_n),
        .bus      (bus),
        .dt_value (dt_value),
        .st_active(st_active),
        .tone     (tone),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_e: edges since reset release; a tick edge is every TICK_DIV-th edge.
    // m_k: edges survived with ST nonzero; tone = parity of m_k / TONE_DIV.
    // A request occupies one accept edge, then executes (op 11 repeats until
    // DT is zero), then spends one edge in the response pulse.
    int         m_e, m_k;
    logic [7:0] m_dt, m_st, m_rd, nd, ns, m_data;
    logic [1:0] m_op;
    bit         m_pend, m_rv, m_done, m_tk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_k = 0; m_dt = 0; m_st = 0; m_rd = 0;
            m_pend = 0; m_rv = 0; m_op = 0; m_data = 0;
        end else begin
            m_tk = ((m_e % TICK_DIV) == TICK_DIV - 1);
            nd = (m_tk && m_dt != 0) ? m_dt - 8'd1 : m_dt;
            ns = (m_tk && m_st != 0) ? m_st - 8'd1 : m_st;
            m_k = (m_st != 0) ? m_k + 1 : 0;
            if (m_pend) begin
                m_done = 1;
                case (m_op)
                    2'd0: m_rd = m_dt;
                    2'd1: begin nd = m_data; m_rd = m_data; end
                    2'd2: begin ns = m_data; m_rd = m_data; end
                    default: if (m_dt == 0) m_rd = 0; else m_done = 0;
                endcase
                m_pend = !m_done;
                m_rv   = m_done;
            end else if (m_rv) begin
                m_rv = 0;
            end else if (bus.req_valid) begin
                m_pend = 1;
                m_op   = bus.req_op;
                m_data = bus.req_data;
            end
            m_dt = nd;
            m_st = ns;
            m_e++;
        end
    end

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        if (rst_n && cmp_en) begin
            check("m_tick", tick, ((m_e % TICK_DIV) == TICK_DIV - 1));
            check("m_dt", dt_value, m_dt);
            check("m_st_active", st_active, (m_st != 0));
            check("m_tone", tone, (m_st != 0) && (((m_k / TONE_DIV) % 2) == 1));
            check("m_req_ready", bus.req_ready, !m_pend && !m_rv);
            check("m_rsp_valid", bus.rsp_valid, m_rv);
            check("m_rsp_data", bus.rsp_data, m_rd);
        end
    end

    always @(posedge clk) begin
        #2;
        if (bus.rsp_valid) rsp_seen = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic [1:0] op, input logic [7:0] d);
        int n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n, ndec, toggles;
        logic [7:0] prev;
        logic prev_tone;
        bit early;

        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check("rst_dt", dt_value, 8'd0);
        check("rst_st_active", st_active, 1'b0);
        check("rst_tone", tone, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 8'd0);

        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1;

        // tick phase after release
        repeat (8) @(negedge clk);
        check("tick_before_first", tick, 1'b0);
        @(negedge clk);
        check("tick_first", tick, 1'b1);
        @(negedge clk);
        check("tick_after_first", tick, 1'b0);
        repeat (9) @(negedge clk);
        check("tick_second", tick, 1'b1);
        check("idle_dt", dt_value, 8'd0);
        check("idle_st", st_active, 1'b0);

        // write DT=3 and count down
        do_req(2'b01, 8'd3);
        check("wr3_rsp_early", bus.rsp_valid, 1'b0);
        check("wr3_busy", bus.req_ready, 1'b0);
        @(negedge clk);
        check("wr3_rsp_valid", bus.rsp_valid, 1'b1);
        check("wr3_rsp_data", bus.rsp_data, 8'd3);
        check("wr3_dt", dt_value, 8'd3);
        @(negedge clk);
        check("wr3_rsp_done", bus.rsp_valid, 1'b0);
        check("wr3_ready_back", bus.req_ready, 1'b1);
        ndec = 0;
        prev = dt_value;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dt_value != prev) begin
                check("dt_step", dt_value, prev - 8'd1);
                ndec++;
                prev = dt_value;
            end
        end
        check("dt_dec_count", ndec, 3);
        check("dt_hold_zero", dt_value, 8'd0);

        // write/tick collision and read/tick collision
        do_req(2'b01, 8'd5);
        repeat (2) @(negedge clk);
        n = 0;
        while (!tick && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("align_tick_found", tick, 1'b1);
        repeat (9) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_data  = 8'h10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("coll_tick_at_exec", tick, 1'b1);
        @(negedge clk);
        check("coll_dt", dt_value, 8'h10);
        check("coll_rsp_valid", bus.rsp_valid, 1'b1);
        check("coll_rsp_data", bus.rsp_data, 8'h10);
        repeat (8) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_data  = 8'hAA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rd_tick_at_exec", tick, 1'b1);
        @(negedge clk);
        check("rd_rsp_valid", bus.rsp_valid, 1'b1);
        check("rd_rsp_data", bus.rsp_data, 8'h10);
        check("rd_dt_after", dt_value, 8'h0F);

        // wait-for-zero with DT=2
        do_req(2'b01, 8'd2);
        repeat (2) @(negedge clk);
        do_req(2'b11, 8'h55);
        early = 0;
        n = 0;
        while (dt_value != 8'd0 && n < 40) begin
            if (bus.rsp_valid || bus.req_ready) early = 1;
            @(negedge clk);
            n++;
        end
        check("wait_dt_reached_zero", dt_value, 8'd0);
        check("wait_no_early_rsp", early, 1'b0);
        check("wait_rsp_at_T", bus.rsp_valid, 1'b0);
        @(negedge clk);
        check("wait_rsp_valid", bus.rsp_valid, 1'b1);
        check("wait_rsp_data", bus.rsp_data, 8'd0);

        // wait with DT already zero
        do_req(2'b11, 8'h77);
        @(negedge clk);
        check("wait0_rsp_valid", bus.rsp_valid, 1'b1);
        check("wait0_rsp_data", bus.rsp_data, 8'd0);

        // sound timer and tone
        do_req(2'b10, 8'd2);
        @(negedge clk);
        check("st_rsp_data", bus.rsp_data, 8'd2);
        check("st_active_on", st_active, 1'b1);
        check("tone_w0", tone, 1'b0);
        repeat (2) @(negedge clk);
        check("tone_w2", tone, 1'b0);
        @(negedge clk);
        check("tone_first_toggle", tone, 1'b1);
        toggles = 1;
        prev_tone = tone;
        n = 0;
        while (st_active && n < 40) begin
            @(negedge clk);
            if (st_active && tone != prev_tone) toggles++;
            prev_tone = tone;
            n++;
        end
        check("st_expired", st_active, 1'b0);
        check("tone_off", tone, 1'b0);
        check("tone_toggles_min", (toggles >= 3), 1'b1);
        repeat (20) @(negedge clk);
        check("st_stays_off", st_active, 1'b0);
        check("tone_stays_off", tone, 1'b0);

        // reset during op-11 wait
        do_req(2'b01, 8'd4);
        repeat (2) @(negedge clk);
        do_req(2'b11, 8'h00);
        repeat (2) @(negedge clk);
        check("pre_rst_waiting", bus.req_ready, 1'b0);
        rsp_seen = 0;
        rst_n = 1'b0;
        #1;
        check("arst_dt", dt_value, 8'd0);
        check("arst_req_ready", bus.req_ready, 1'b1);
        check("arst_rsp_valid", bus.rsp_valid, 1'b0);
        check("arst_tick", tick, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        check("arst_first_tick", tick, 1'b1);
        repeat (40) @(negedge clk);
        check("arst_no_rsp", rsp_seen, 1'b0);
        check("arst_idle_ready", bus.req_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chip8_timer_ctrl.md
# chip8_timer_ctrl

Controller for the Chip-8 delay timer (DT) and sound timer (ST). Owns both 8-bit timer registers, one shared 60 Hz tick generator and the buzzer tone generator, and sequences CPU accesses (Fx07 read DT, Fx15 set DT, Fx18 set ST, and wait-for-DT-zero) through a single request/response handshake. Sits between the CPU execute stage and the audio/output pins.

## Interface
- TICK_DIV, 1666667, SYS_CLK cycles per 60 Hz tick (100 MHz clock); must be ≥ 2
- TONE_DIV, 113636, SYS_CLK cycles per buzzer half-period (~440 Hz); must be ≥ 1
- SYS_CLK  in  1  system clock; all state updates on rising edge
- SYS_RST_N  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_op  in  2  00 = read DT, 01 = write DT, 10 = write ST, 11 = wait until DT == 0
- req_data  in  8  write value for ops 01 and 10; ignored otherwise
- req_ready  out  1  controller can accept a request
- rsp_valid  out  1  one-cycle completion pulse, for every op
- rsp_data  out  8  DT value for op 00; 0 for op 11; written value for ops 01 and 10
- dt_value  out  8  current DT register
- st_active  out  1  ST != 0
- tone  out  1  buzzer square wave
- tick  out  1  one-cycle 60 Hz tick pulse

## Operation
- Reset values: DT = 0, ST = 0, tick counter = 0, tone counter = 0, tone = 0, tick = 0, state IDLE, req_ready = 1, rsp_valid = 0, rsp_data = 0.
- Tick counter: free-running, ceil(log2(TICK_DIV)) bits. Counts 0..TICK_DIV-1 and wraps to 0. tick = 1 while the counter equals TICK_DIV-1. Never reset by requests.
- Decrement on a tick edge: each timer that is nonzero decrements by 1. A timer at 0 stays 0, with no wrap to 0xFF.
- Write/tick collision:
  - If a write to a timer executes on a tick edge, that timer loads the written value and does not decrement.
  - The other timer still decrements.
- Read/tick collision: a DT read executing on a tick edge returns the pre-decrement value.
- FSM states:
  - IDLE: req_ready = 1. If req_valid is high, capture req_op and req_data, then go to EXEC.
  - EXEC:
    - Op 00: rsp_data ← DT.
    - Op 01: DT ← data and rsp_data ← data.
    - Op 10: ST ← data and rsp_data ← data.
    - For ops 00, 01 and 10, go to RESP.
    - Op 11: remain in EXEC until DT == 0 at the start of the cycle, then set rsp_data ← 0 and go to RESP. If DT is already 0, this takes a single EXEC cycle.
  - RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- req_ready = 0 in EXEC and RESP. Requests are not queued; req_valid is ignored outside IDLE.
- Tone generator:
  - While ST != 0, the tone counter counts 0..TONE_DIV-1, and tone toggles on each wrap.
  - While ST == 0, tone = 0 and the tone counter is held at 0.
  - When ST is written from 0 to nonzero, the first toggle occurs TONE_DIV cycles later.
- st_active and dt_value are combinational views of the registers.

## Timing
- Request accepted at edge E0 (req_valid and req_ready both high).
  - Ops 00, 01 and 10 execute at E1; rsp_valid is high from E1 to E2; req_ready returns high after E2.
  - Throughput is 1 request per 3 cycles.
- Op 11 latency is unbounded. It completes at the first EXEC edge where DT == 0, so a DT decrement to 0 at tick edge T gives the response at T+1.
- Asynchronous reset, including mid-EXEC or mid-wait:
  - All state returns to reset values immediately.
  - A pending request is dropped and no rsp_valid is produced.
  - After release, the first tick occurs TICK_DIV cycles later.

## Test plan
Bench uses TICK_DIV=10 and TONE_DIV=3.
- Reset, then release: check all outputs are at reset values. tick pulses first on cycle 10, then every 10 cycles; DT and ST stay 0 and tone stays 0.
- Write DT=3 (op 01):
  - Response: rsp_valid pulses 2 cycles after acceptance with rsp_data=3.
  - Countdown: dt_value goes 3→2→1→0 on successive tick edges, then holds 0 (no 0xFF).
- Set DT=5, then issue write DT=0x10 so that EXEC coincides with a tick edge:
  - dt_value = 0x10, not 0x0F.
  - A read (op 00) executing on the next tick edge returns 0x10, then DT becomes 0x0F.
- DT=2, then op 11:
  - req_ready stays 0 and there is no rsp_valid across the first tick.
  - rsp_valid pulses one cycle after the second tick with rsp_data=0.
  - Op 11 issued with DT=0 responds 2 cycles after acceptance.
- Write ST=2:
  - st_active=1; tone toggles every 3 cycles.
  - After 2 ticks, st_active=0 and tone=0, and both remain 0.
- Assert SYS_RST_N low mid op-11 wait with DT=4: DT=0, state IDLE, req_ready=1 immediately, and no rsp_valid ever emitted for that request.
